// File: rtl/morse_stream_decoder_if.sv
// morse_stream_decoder_if: symbol input stream and decoded-character output stream.
interface morse_stream_decoder_if #(parameter int CHAR_W = 8);
    logic [1:0]        sym;
    logic              sym_valid;
    logic              sym_ready;
    logic [CHAR_W-1:0] out_char;
    logic              out_err;
    logic              out_valid;
    logic              out_ready;
    modport master(output sym, sym_valid, out_ready, input sym_ready, out_char, out_err, out_valid);
    modport slave(input sym, sym_valid, out_ready, output sym_ready, out_char, out_err, out_valid);
endinterface

// File: rtl/morse_stream_decoder.sv
// morse_stream_decoder: dot/dash/EOC symbol stream to ASCII characters through an output FIFO.
// Define MORSE_SEG7_EN to drive seg with an active-low 7-segment image of the FIFO head.
module morse_stream_decoder #(
    parameter int MAX_LEN    = 6,
    parameter int FIFO_DEPTH = 4,
    parameter int CHAR_W     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    morse_stream_decoder_if.slave  bus,
    output logic [7:0]             seg,
    output logic                   drop,
    input  logic                   clr_drop
);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    // Heap-ordered Morse tree: node i has dot child 2i+1 and dash child 2i+2; '?' marks unassigned codes
    localparam logic [63*8-1:0] TREE = " ETIANMSURWDKGOHVF?L?PJBXCYZQ??54?3???2???????16???????7???8?90";

    typedef enum logic [1:0] {IDLE, COLLECT, DISCARD, DECODE} state_t;

    state_t             state, state_n;
    logic [LW-1:0]      len, len_n;
    logic [MAX_LEN-1:0] pat, pat_n;
    logic               ovf, ovf_n;
    logic               acc, mark, eoc;
    logic [5:0]         idx;
    logic [7:0]         dec_char;
    logic               dec_err;

    assign bus.sym_ready = state != DECODE;
    assign acc  = bus.sym_valid && bus.sym_ready;
    assign mark = acc && ^bus.sym;
    assign eoc  = acc && &bus.sym;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state <= IDLE;
            len   <= '0;
            pat   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_n;
            len   <= len_n;
            pat   <= pat_n;
            ovf   <= ovf_n;
        end

    always_comb begin
        state_n = state;
        len_n   = len;
        pat_n   = pat;
        ovf_n   = ovf;
        case (state)
            IDLE:
                if (mark) begin
                    state_n = COLLECT;
                    len_n   = LW'(1);
                    pat_n   = MAX_LEN'(bus.sym[1]);
                end else if (eoc) state_n = DECODE;
            COLLECT:
                if (mark && 32'(len) == MAX_LEN) begin
                    state_n = DISCARD;
                    ovf_n   = 1'b1;
                end else if (mark) begin
                    len_n = len + LW'(1);
                    pat_n = MAX_LEN'({pat, bus.sym[1]});
                end else if (eoc) state_n = DECODE;
            DISCARD:
                if (eoc) state_n = DECODE;
            default: begin
                state_n = IDLE;
                len_n   = '0;
                pat_n   = '0;
                ovf_n   = 1'b0;
            end
        endcase
    end

    // Only codes of up to five symbols exist in the tree; longer ones are unlisted
    assign idx      = 6'((32'd1 << len) - 32'd1 + 32'(pat[4:0]));
    assign dec_char = (ovf || 32'(len) > 5) ? 8'h3F : TREE[8*(62-int'(idx)) +: 8];
    assign dec_err  = dec_char == 8'h3F;

    logic [CHAR_W:0] mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic            wr, full, push, pop;

    assign wr            = state == DECODE;
    assign full          = 32'(count) == FIFO_DEPTH;
    assign pop           = bus.out_valid && bus.out_ready;
    assign push          = wr && (!full || pop);
    assign bus.out_valid = count != '0;
    assign bus.out_char  = bus.out_valid ? mem[rd_ptr][CHAR_W-1:0] : '0;
    assign bus.out_err   = bus.out_valid && mem[rd_ptr][CHAR_W];

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= {dec_err, CHAR_W'(dec_char)};

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            drop   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            drop  <= (wr && !push) || (drop && !clr_drop);
        end

`ifdef MORSE_SEG7_EN
    always_comb begin
        seg = 8'hFF;
        if (bus.out_valid)
            case (bus.out_char)
                "0": seg = 8'h81;
                "1": seg = 8'hCF;
                "2": seg = 8'h92;
                "3": seg = 8'h86;
                "4": seg = 8'hCC;
                "5": seg = 8'hA4;
                "6": seg = 8'hA0;
                "7": seg = 8'h8F;
                "8": seg = 8'h80;
                "9": seg = 8'h84;
                "A": seg = 8'h88;
                "B": seg = 8'hE0;
                "C": seg = 8'hB1;
                "D": seg = 8'hC2;
                "E": seg = 8'hB0;
                "F": seg = 8'hB8;
                default: seg = 8'hFF;
            endcase
    end
`else
    assign seg = 8'hFF;
`endif
endmodule

// File: tb/tb_morse_stream_decoder.sv
// tb_morse_stream_decoder: directed and randomized checks of the Morse decoder against a
// table-driven model of ITU codes, length limit and FIFO behaviour.
module tb_morse_stream_decoder;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clr_drop = 1'b0;
    logic [7:0] seg;
    logic drop;
    int tests = 0;
    int fails = 0;
    logic [16:0] got [$];

    string alpha = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789";
    string codes [36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
                          "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
                          "..-", "...-", ".--", "-..-", "-.--", "--..",
                          "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...",
                          "---..", "----."};

    morse_stream_decoder_if #(.CHAR_W(8)) bus();

    morse_stream_decoder dut (
        .clk(clk), .rst(rst), .bus(bus), .seg(seg), .drop(drop), .clr_drop(clr_drop)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (bus.out_valid && bus.out_ready) got.push_back({seg, bus.out_err, bus.out_char});

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1);
    end

    function automatic logic [7:0] seg_model(input logic [7:0] c);
`ifdef MORSE_SEG7_EN
        case (c)
            "0": return 8'h81; "1": return 8'hCF; "2": return 8'h92; "3": return 8'h86;
            "4": return 8'hCC; "5": return 8'hA4; "6": return 8'hA0; "7": return 8'h8F;
            "8": return 8'h80; "9": return 8'h84; "A": return 8'h88; "B": return 8'hE0;
            "C": return 8'hB1; "D": return 8'hC2; "E": return 8'hB0; "F": return 8'hB8;
            default: return 8'hFF;
        endcase
`else
        return c == 8'h00 ? 8'hFF : 8'hFF;
`endif
    endfunction

    // Expected {seg, err, char} for a dot/dash string, straight from the code table
    function automatic logic [16:0] model(input string c);
        if (c.len() == 0) return {seg_model(8'h20), 1'b0, 8'h20};
        if (c.len() > 6) return {8'hFF, 1'b1, 8'h3F};
        for (int i = 0; i < 36; i++)
            if (codes[i] == c) return {seg_model(alpha[i]), 1'b0, alpha[i]};
        return {8'hFF, 1'b1, 8'h3F};
    endfunction

    task automatic send(input logic [1:0] s);
        int n = 0;
        bus.sym = s;
        bus.sym_valid = 1'b1;
        while (!bus.sym_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (n == 10) begin
            tests++; fails++;
            $display("FAIL send_timeout: sym_ready stayed %b, required 1", bus.sym_ready);
        end
        @(posedge clk); #1;
        bus.sym_valid = 1'b0;
        bus.sym = 2'b00;
    endtask

    task automatic run_code(input string c);
        for (int i = 0; i < c.len(); i++) send(c[i] == "-" ? 2'b10 : 2'b01);
        send(2'b11);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
        tests++; if (bus.out_char !== 8'h00) begin fails++; $display("FAIL reset_char: got %h want 00", bus.out_char); end
        tests++; if (bus.out_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", bus.out_err); end
        tests++; if (drop !== 1'b0) begin fails++; $display("FAIL reset_drop: got %b want 0", drop); end
        tests++; if (bus.sym_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", bus.sym_ready); end
        tests++; if (seg !== 8'hFF) begin fails++; $display("FAIL reset_seg: got %h want ff", seg); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        got.delete();
        send(2'b01);
        send(2'b10);
        send(2'b11);
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL a_early: out_valid %b at E0, want 0", bus.out_valid); end
        tests++; if (bus.sym_ready !== 1'b0) begin fails++; $display("FAIL a_ready: sym_ready %b in decode, want 0", bus.sym_ready); end
        @(posedge clk); #1;
        tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL a_valid: out_valid %b at E1, want 1", bus.out_valid); end
        tests++; if (bus.out_char !== 8'h41) begin fails++; $display("FAIL a_char: got %h want 41", bus.out_char); end
        tests++; if (bus.out_err !== 1'b0) begin fails++; $display("FAIL a_err: got %b want 0", bus.out_err); end
        tests++; if (seg !== seg_model(8'h41)) begin fails++; $display("FAIL a_seg: got %h want %h", seg, seg_model(8'h41)); end
        @(posedge clk); #1;
        tests++; if (bus.out_valid !== 1'b0 || got.size() != 1) begin fails++; $display("FAIL a_pulse: out_valid %b entries %0d, want 0 and 1", bus.out_valid, got.size()); end
    endtask

    task automatic test_codes();
        string list [6] = '{"-----", ".----", ".......", ".", ".-..--", ""};
        got.delete();
        foreach (list[i]) run_code(list[i]);
        repeat (3) @(posedge clk);
        #1;
        tests++; if (got.size() != 6) begin fails++; $display("FAIL codes_count: got %0d want 6", got.size()); end
        foreach (list[i])
            if (i < got.size()) begin
                tests++;
                if (got[i] !== model(list[i])) begin
                    fails++;
                    $display("FAIL codes_%0d '%s': got seg/err/char %h want %h", i, list[i], got[i], model(list[i]));
                end
            end
    endtask

    task automatic test_fifo_full();
        bus.out_ready = 1'b0;
        repeat (5) run_code(".");
        repeat (2) @(posedge clk);
        #1;
        tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL full_valid: got %b want 1", bus.out_valid); end
        tests++; if (drop !== 1'b1) begin fails++; $display("FAIL full_drop: got %b want 1", drop); end
        clr_drop = 1'b1;
        @(posedge clk); #1;
        clr_drop = 1'b0;
        tests++; if (drop !== 1'b0) begin fails++; $display("FAIL clr_drop: got %b want 0", drop); end
        got.delete();
        bus.out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        tests++; if (got.size() != 4) begin fails++; $display("FAIL drain_count: got %0d want 4", got.size()); end
        foreach (got[i]) begin
            tests++;
            if (got[i][8:0] !== 9'h045) begin fails++; $display("FAIL drain_%0d: got err/char %h want 045", i, got[i][8:0]); end
        end
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL drain_empty: out_valid %b want 0", bus.out_valid); end
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        repeat (5) run_code(".");
        send(2'b10);
        send(2'b10);
        tests++; if (bus.out_valid !== 1'b1 || drop !== 1'b1) begin fails++; $display("FAIL pre_reset: valid %b drop %b want 1 1", bus.out_valid, drop); end
        #2 rst = 1'b0;
        #1;
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL async_valid: got %b want 0", bus.out_valid); end
        tests++; if (drop !== 1'b0) begin fails++; $display("FAIL async_drop: got %b want 0", drop); end
        @(negedge clk);
        rst = 1'b1;
        bus.out_ready = 1'b1;
        got.delete();
        @(posedge clk); #1;
        run_code(".");
        repeat (3) @(posedge clk);
        #1;
        tests++; if (got.size() != 1) begin fails++; $display("FAIL post_reset_count: got %0d want 1", got.size()); end
        if (got.size() > 0) begin
            tests++; if (got[0][8:0] !== 9'h045) begin fails++; $display("FAIL post_reset_char: got %h want 045", got[0][8:0]); end
        end
    endtask

    task automatic test_back_to_back();
        got.delete();
        bus.sym = 2'b11;
        bus.sym_valid = 1'b1;
        @(posedge clk); #1;
        tests++; if (bus.sym_ready !== 1'b0) begin fails++; $display("FAIL b2b_stall: sym_ready %b want 0", bus.sym_ready); end
        @(posedge clk); #1;
        tests++; if (bus.sym_ready !== 1'b1) begin fails++; $display("FAIL b2b_resume: sym_ready %b want 1", bus.sym_ready); end
        @(posedge clk); #1;
        bus.sym_valid = 1'b0;
        bus.sym = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (got.size() != 2) begin fails++; $display("FAIL b2b_count: got %0d want 2", got.size()); end
        foreach (got[i]) begin
            tests++;
            if (got[i][8:0] !== 9'h020) begin fails++; $display("FAIL b2b_%0d: got %h want 020", i, got[i][8:0]); end
        end
    endtask

    task automatic test_random();
        logic [16:0] exp [$];
        got.delete();
        for (int k = 0; k < 40; k++) begin
            string c = "";
            if ($urandom_range(0, 3) != 0) c = codes[$urandom_range(0, 35)];
            else for (int j = $urandom_range(0, 8); j > 0; j--) c = {c, $urandom_range(0, 1) ? "-" : "."};
            exp.push_back(model(c));
            for (int i = 0; i < c.len(); i++) begin
                if ($urandom_range(0, 4) == 0) send(2'b00);
                if ($urandom_range(0, 4) == 0) begin @(posedge clk); #1; end
                send(c[i] == "-" ? 2'b10 : 2'b01);
            end
            send(2'b11);
        end
        repeat (4) @(posedge clk);
        #1;
        tests++; if (got.size() != exp.size()) begin fails++; $display("FAIL rand_count: got %0d want %0d", got.size(), exp.size()); end
        foreach (exp[i])
            if (i < got.size()) begin
                tests++;
                if (got[i] !== exp[i]) begin fails++; $display("FAIL rand_%0d: got seg/err/char %h want %h", i, got[i], exp[i]); end
            end
    endtask

    initial begin
        bus.sym = 2'b00;
        bus.sym_valid = 1'b0;
        bus.out_ready = 1'b1;
        test_reset();
        test_basic();
        test_codes();
        test_fifo_full();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
